nv_nvdla_attn_cbuf_rd_gbox: RTL and testbench
=============================================

Name: nv_nvdla_attn_cbuf_rd_gbox

Overview:
- Parametrised CBUF read gearbox for the attention datapath. It replaces the free-running 512→128 chunk selector that sat inside the attention wrapper.
- Round-robin arbitrates NUM_CH read clients (Q/K/V/mask by default) onto the single CBUF read port, one outstanding line at a time.
- Captures each returned CBUF_DW line and serialises it into RATIO = CBUF_DW/OUT_DW beats on a shared valid/ready output tagged with channel id.
- Adds read-latency timeout detection and a sticky error status; the previous selector had neither.

Parameters:
- NUM_CH, 4: number of read clients.
- CBUF_DW, 512: CBUF read data width.
- OUT_DW, 128: output beat width; CBUF_DW must be an integer multiple of it (RATIO ≥ 1).
- ADDR_W, 15: CBUF address width.
- TIMEOUT, 255: max cycles in WAIT before error (8-bit counter sized from this).

Ports:
- nvdla_core_clk  in  1  core clock
- nvdla_core_rst  in  1  asynchronous, active-high reset
- ch_req_vld  in  NUM_CH  per-channel read request
- ch_req_addr  in  NUM_CH*ADDR_W  flattened per-channel line address (ch i at [i*ADDR_W +: ADDR_W])
- ch_req_rdy  out  NUM_CH  one-hot grant/accept
- cbuf_rd_en  out  1  CBUF read strobe
- cbuf_rd_addr  out  ADDR_W  CBUF read address
- cbuf_rd_data  in  CBUF_DW  CBUF read data
- cbuf_rd_valid  in  1  CBUF read data valid
- out_vld  out  1  beat valid
- out_rdy  in  1  beat ready
- out_data  out  OUT_DW  beat payload
- out_ch  out  max(1,$clog2(NUM_CH))  channel id of beat
- out_last  out  1  final beat of line
- err_clr  in  1  clears sticky error
- busy  out  1  FSM not IDLE
- err_timeout  out  1  sticky timeout flag

Behaviour:
- Clock and reset: one clock, nvdla_core_clk. Reset nvdla_core_rst is asynchronous and active-high.
- Reset values:
  - All outputs 0; FSM = IDLE.
  - RR pointer = 0; beat counter = 0; timeout counter = 0.
  - Line buffer contents don't-care.
  - Reset mid-operation aborts the line; no further beats appear.
- FSM states: IDLE, ISSUE, WAIT, DRAIN.
- IDLE:
  - If any ch_req_vld, grant the first requesting channel at or after the RR pointer (wrapping).
  - ch_req_rdy[g] = 1 combinationally that cycle; latch addr and g.
  - RR pointer ← (g+1) mod NUM_CH.
  - Go to ISSUE.
- ISSUE:
  - cbuf_rd_en = 1 and cbuf_rd_addr = latched addr for exactly one cycle.
  - Go to WAIT; clear timeout counter.
- WAIT:
  - On cbuf_rd_valid, capture cbuf_rd_data into the line buffer, set beat counter = 0, go to DRAIN.
  - Otherwise increment the counter. When it reaches TIMEOUT, set err_timeout = 1 and return to IDLE without emitting beats.
- cbuf_rd_valid in any state other than WAIT is ignored.
- DRAIN:
  - out_vld = 1; out_data = line[beat*OUT_DW +: OUT_DW], low chunk first; out_ch = g; out_last = (beat == RATIO-1).
  - On out_vld & out_rdy: if last, go to IDLE, else beat++.
  - Outputs hold stable while out_rdy = 0.
- Latency:
  - Grant → cbuf_rd_en is 1 cycle.
  - cbuf_rd_valid → first out_vld is 1 cycle (registered).
  - Minimum per line is RATIO + 3 cycles plus CBUF latency.
- No new grant is issued until DRAIN completes: ch_req_rdy is 0 outside IDLE.
- RATIO = 1: each line is a single beat with out_last = 1.
- err_timeout:
  - Set has priority over err_clr in the same cycle.
  - Otherwise err_clr clears it.
  - The error does not block further requests.
- busy = (state != IDLE).

Decomposition:
- Shared package nv_nvdla_attn_pkg holds:
  - FSM state enum (2 bits).
  - Default widths: CBUF_DW, OUT_DW, ADDR_W.
  - The channel-index constants CH_Q=0, CH_K=1, CH_V=2, CH_MASK=3.
- One natural sub-module: nv_nvdla_attn_rr_arb, a parametrised NUM_CH round-robin arbiter.
  - Inputs: req vector, pointer, enable.
  - Outputs: one-hot grant and encoded index.
- Line buffer and serialiser stay inline.

Test Plan:
- Single request:
  - Stimulus: ch 2, addr 0x0123; CBUF returns {128'hD,128'hC,128'hB,128'hA} 3 cycles after cbuf_rd_en.
  - Required: cbuf_rd_addr = 0x0123; out beats A, B, C, D with out_ch = 2; out_last only on D; busy drops the cycle after D is accepted.
- Round-robin:
  - Stimulus: ch 0–3 request continuously from reset.
  - Required: grant order 0, 1, 2, 3, 0. Then with only ch 1 and ch 3 requesting after pointer = 2: order 3, 1, 3.
- Backpressure:
  - Stimulus: out_rdy toggling 1,0,0,1 during DRAIN.
  - Required: out_data and out_ch stable while stalled; exactly 4 beats; no dropped or repeated chunk.
- Timeout:
  - Stimulus: TIMEOUT = 8; no cbuf_rd_valid.
  - Required: err_timeout rises 8 cycles into WAIT; FSM is back in IDLE; next request served normally.
  - Then: err_clr = 1 clears it; err_clr coincident with a new timeout leaves it set.
- Spurious valid and reset:
  - Stimulus: cbuf_rd_valid while in IDLE.
  - Required: ignored (no out_vld).
  - Stimulus: assert nvdla_core_rst mid-DRAIN after beat 1.
  - Required: out_vld = 0 and ch_req_rdy = 0 immediately (async); after reset the first grant goes to ch 0.
- Parameter sweep:
  - Stimulus: CBUF_DW=256, OUT_DW=256, NUM_CH=1.
  - Required: single beat with out_last = 1; out_ch width 1 and value 0.

Source files
------------

// File: rtl/nv_nvdla_attn_pkg.sv
// Shared types and default widths for the attention CBUF read path.
package nv_nvdla_attn_pkg;

   localparam int unsigned ATTN_CBUF_DW = 512;
   localparam int unsigned ATTN_OUT_DW  = 128;
   localparam int unsigned ATTN_ADDR_W  = 15;

   // Read client indices on the gearbox request ports
   localparam int unsigned CH_Q    = 0;
   localparam int unsigned CH_K    = 1;
   localparam int unsigned CH_V    = 2;
   localparam int unsigned CH_MASK = 3;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_WAIT  = 2'd2,
      ST_DRAIN = 2'd3
   } attn_rd_state_e;

endpackage

// File: rtl/nv_nvdla_attn_rr_arb.sv
// Round-robin arbiter: first requester at or after ptr (wrapping) wins.
module nv_nvdla_attn_rr_arb #(
   parameter  int unsigned NUM_CH = 4,
   localparam int unsigned CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
   input  logic [NUM_CH-1:0] req,
   input  logic [CH_W-1:0]   ptr,
   input  logic              en,
   output logic [NUM_CH-1:0] gnt,
   output logic [CH_W-1:0]   gnt_idx
);

   logic [2*NUM_CH-1:0] req2;
   logic [NUM_CH-1:0]   rot;
   logic                found;

   // Rotate requests so the pointer channel sits at bit 0
   assign req2 = {req, req};
   assign rot  = NUM_CH'(req2 >> ptr);

   // Priority scan of the rotated vector, mapped back to a channel index
   always_comb begin
      found   = 1'b0;
      gnt_idx = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         if (en && !found && rot[i]) begin
            found   = 1'b1;
            gnt_idx = CH_W'((32'(ptr) + 32'(i)) % NUM_CH);
         end
      end
   end

   assign gnt = found ? (NUM_CH'(1) << gnt_idx) : '0;

endmodule

// File: rtl/nv_nvdla_attn_cbuf_rd_gbox.sv
// CBUF read gearbox: arbitrates read clients, fetches one line at a time
// and serialises it into OUT_DW beats tagged with the channel id.
module nv_nvdla_attn_cbuf_rd_gbox
   import nv_nvdla_attn_pkg::*;
#(
   parameter  int unsigned NUM_CH  = 4,
   parameter  int unsigned CBUF_DW = ATTN_CBUF_DW,
   parameter  int unsigned OUT_DW  = ATTN_OUT_DW,
   parameter  int unsigned ADDR_W  = ATTN_ADDR_W,
   parameter  int unsigned TIMEOUT = 255,
   localparam int unsigned CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
   input  logic                     nvdla_core_clk,
   input  logic                     nvdla_core_rst,
   input  logic [NUM_CH-1:0]        ch_req_vld,
   input  logic [NUM_CH*ADDR_W-1:0] ch_req_addr,
   output logic [NUM_CH-1:0]        ch_req_rdy,
   output logic                     cbuf_rd_en,
   output logic [ADDR_W-1:0]        cbuf_rd_addr,
   input  logic [CBUF_DW-1:0]       cbuf_rd_data,
   input  logic                     cbuf_rd_valid,
   output logic                     out_vld,
   input  logic                     out_rdy,
   output logic [OUT_DW-1:0]        out_data,
   output logic [CH_W-1:0]          out_ch,
   output logic                     out_last,
   input  logic                     err_clr,
   output logic                     busy,
   output logic                     err_timeout
);

   localparam int unsigned RATIO  = CBUF_DW / OUT_DW;
   localparam int unsigned BEAT_W = (RATIO > 1) ? $clog2(RATIO) : 1;
   localparam int unsigned TO_W   = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
   localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(RATIO - 1);
   localparam logic [TO_W-1:0]   TO_LAST   = TO_W'(TIMEOUT - 1);

   attn_rd_state_e    state_q, state_d;
   logic [CH_W-1:0]   ptr_q, ch_q, gnt_idx;
   logic [NUM_CH-1:0] gnt;
   logic [ADDR_W-1:0] addr_q, sel_addr;
   logic [BEAT_W-1:0] beat_q;
   logic [TO_W-1:0]   to_cnt_q;
   logic [CBUF_DW-1:0] line_q;
   logic [OUT_DW-1:0] chunk;
   logic              err_q;
   logic              grant_c, capture_c, timeout_c, accept_c, last_c;

   nv_nvdla_attn_rr_arb #(.NUM_CH(NUM_CH)) u_arb (
      .req     (ch_req_vld),
      .ptr     (ptr_q),
      .en      (state_q == ST_IDLE),
      .gnt     (gnt),
      .gnt_idx (gnt_idx)
   );

   assign sel_addr = ADDR_W'(ch_req_addr >> (32'(gnt_idx) * ADDR_W));
   assign chunk    = OUT_DW'(line_q >> (32'(beat_q) * OUT_DW));

   // Next-state and per-cycle event decode
   always_comb begin
      state_d   = state_q;
      grant_c   = 1'b0;
      capture_c = 1'b0;
      timeout_c = 1'b0;
      accept_c  = 1'b0;
      last_c    = (beat_q == LAST_BEAT);
      case (state_q)
         ST_IDLE: begin
            if (|ch_req_vld) begin
               grant_c = 1'b1;
               state_d = ST_ISSUE;
            end
         end
         ST_ISSUE: state_d = ST_WAIT;
         ST_WAIT: begin
            if (cbuf_rd_valid) begin
               capture_c = 1'b1;
               state_d   = ST_DRAIN;
            end else if (to_cnt_q == TO_LAST) begin
               timeout_c = 1'b1;
               state_d   = ST_IDLE;
            end
         end
         ST_DRAIN: begin
            if (out_rdy) begin
               accept_c = 1'b1;
               if (last_c) state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // FSM state register
   always_ff @(posedge nvdla_core_clk or posedge nvdla_core_rst) begin
      if (nvdla_core_rst) state_q <= ST_IDLE;
      else                state_q <= state_d;
   end

   // Grant latch, RR pointer, beat/timeout counters and sticky error
   always_ff @(posedge nvdla_core_clk or posedge nvdla_core_rst) begin
      if (nvdla_core_rst) begin
         ptr_q    <= '0;
         ch_q     <= '0;
         addr_q   <= '0;
         beat_q   <= '0;
         to_cnt_q <= '0;
         err_q    <= 1'b0;
      end else begin
         if (grant_c) begin
            ch_q   <= gnt_idx;
            addr_q <= sel_addr;
            ptr_q  <= (gnt_idx == CH_W'(NUM_CH - 1)) ? '0 : gnt_idx + CH_W'(1);
         end
         if (state_q == ST_ISSUE)     to_cnt_q <= '0;
         else if (state_q == ST_WAIT) to_cnt_q <= to_cnt_q + TO_W'(1);
         if (capture_c)                 beat_q <= '0;
         else if (accept_c && !last_c)  beat_q <= beat_q + BEAT_W'(1);
         if (timeout_c)    err_q <= 1'b1;
         else if (err_clr) err_q <= 1'b0;
      end
   end

   // Line buffer; contents are only meaningful in DRAIN so no reset
   always_ff @(posedge nvdla_core_clk) begin
      if (capture_c) line_q <= cbuf_rd_data;
   end

   // Grant is combinational in IDLE and forced low while reset is held
   assign ch_req_rdy   = nvdla_core_rst ? '0 : gnt;
   assign cbuf_rd_en   = (state_q == ST_ISSUE);
   assign cbuf_rd_addr = cbuf_rd_en ? addr_q : '0;
   assign out_vld      = (state_q == ST_DRAIN);
   assign out_data     = out_vld ? chunk : '0;
   assign out_ch       = out_vld ? ch_q : '0;
   assign out_last     = out_vld & last_c;
   assign busy         = (state_q != ST_IDLE);
   assign err_timeout  = err_q;

endmodule

// File: tb/tb_nv_nvdla_attn_cbuf_rd_gbox.sv
// Directed bench for the CBUF read gearbox (4-channel and 1-channel builds).
module tb_nv_nvdla_attn_cbuf_rd_gbox;

   localparam int unsigned AW = 15;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   // Main instance: 4 channels, 512 -> 128, short timeout
   logic [3:0]     req_vld, req_rdy;
   logic [4*AW-1:0] req_addr;
   logic           rd_en, rd_valid, o_vld, o_rdy, o_last, err_clr, busy, err;
   logic [AW-1:0]  rd_addr;
   logic [511:0]   rd_data;
   logic [127:0]   o_data;
   logic [1:0]     o_ch;

   // Sweep instance: 1 channel, 256 -> 256
   logic [0:0]     s_req_vld, s_req_rdy;
   logic [AW-1:0]  s_req_addr, s_rd_addr;
   logic           s_rd_en, s_rd_valid, s_o_vld, s_o_rdy, s_o_last, s_busy, s_err;
   logic [255:0]   s_rd_data, s_o_data;
   logic [0:0]     s_o_ch;

   nv_nvdla_attn_cbuf_rd_gbox #(.NUM_CH(4), .CBUF_DW(512), .OUT_DW(128), .ADDR_W(AW), .TIMEOUT(8)) u_dut (
      .nvdla_core_clk(clk), .nvdla_core_rst(rst),
      .ch_req_vld(req_vld), .ch_req_addr(req_addr), .ch_req_rdy(req_rdy),
      .cbuf_rd_en(rd_en), .cbuf_rd_addr(rd_addr), .cbuf_rd_data(rd_data), .cbuf_rd_valid(rd_valid),
      .out_vld(o_vld), .out_rdy(o_rdy), .out_data(o_data), .out_ch(o_ch), .out_last(o_last),
      .err_clr(err_clr), .busy(busy), .err_timeout(err)
   );

   nv_nvdla_attn_cbuf_rd_gbox #(.NUM_CH(1), .CBUF_DW(256), .OUT_DW(256), .ADDR_W(AW), .TIMEOUT(8)) u_dut1 (
      .nvdla_core_clk(clk), .nvdla_core_rst(rst),
      .ch_req_vld(s_req_vld), .ch_req_addr(s_req_addr), .ch_req_rdy(s_req_rdy),
      .cbuf_rd_en(s_rd_en), .cbuf_rd_addr(s_rd_addr), .cbuf_rd_data(s_rd_data), .cbuf_rd_valid(s_rd_valid),
      .out_vld(s_o_vld), .out_rdy(s_o_rdy), .out_data(s_o_data), .out_ch(s_o_ch), .out_last(s_o_last),
      .err_clr(1'b0), .busy(s_busy), .err_timeout(s_err)
   );

   int unsigned n_vec = 0;
   int unsigned n_err = 0;

   task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Waits for a grant, answers the read after lat WAIT cycles and drains the line.
   // Entered just after a negedge with requests driven; returns on a negedge in IDLE.
   task automatic serve(input logic [511:0] line, input int lat, output int gidx);
      int n;
      n    = 0;
      gidx = -1;
      #1;
      while (req_rdy == 4'b0 && n < 20) begin
         @(negedge clk); #1; n++;
      end
      for (int i = 0; i < 4; i++) if (req_rdy[i]) gidx = i;
      @(negedge clk);
      repeat (lat) @(negedge clk);
      rd_valid = 1'b1; rd_data = line;
      @(negedge clk);
      rd_valid = 1'b0; rd_data = '0; o_rdy = 1'b1;
      n = 0;
      #1;
      while (!(o_vld && o_last) && n < 20) begin
         @(negedge clk); #1; n++;
      end
      if (n >= 20) check("serve_drain_timeout", 512'(0), 512'(1));
      @(negedge clk);
      o_rdy = 1'b0;
   endtask

   logic [127:0] exp1 [4] = '{128'hA, 128'hB, 128'hC, 128'hD};
   logic [127:0] exp2 [4] = '{128'hE0, 128'hF1, 128'hA2, 128'hB3};
   logic [127:0] exp3 [4] = '{128'h30, 128'h31, 128'h32, 128'h33};
   int           rr_exp [9] = '{0, 1, 2, 3, 0, 1, 3, 1, 3};
   logic [511:0] any_line;
   logic [127:0] prev_data;
   logic [1:0]   prev_ch;
   logic         prev_stall;
   int           g, k, cyc;

   initial begin
      rst = 1'b1; req_vld = '0; req_addr = '0; rd_data = '0; rd_valid = 1'b0;
      o_rdy = 1'b0; err_clr = 1'b0;
      s_req_vld = '0; s_req_addr = '0; s_rd_data = '0; s_rd_valid = 1'b0; s_o_rdy = 1'b0;
      any_line = {128'h4, 128'h3, 128'h2, 128'h1};

      // Reset values
      repeat (2) @(negedge clk);
      #1;
      check("rst_busy", 512'(busy), 512'(0));
      check("rst_rdy", 512'(req_rdy), 512'(0));
      check("rst_rd_en", 512'(rd_en), 512'(0));
      check("rst_out_vld", 512'(o_vld), 512'(0));
      check("rst_err", 512'(err), 512'(0));
      @(negedge clk); rst = 1'b0;
      @(negedge clk);

      // Single request on ch 2, data 3 cycles after the read strobe
      req_vld = 4'b0100; req_addr[2*AW +: AW] = 15'h0123;
      #1 check("t1_gnt", 512'(req_rdy), 512'(4'b0100));
      @(negedge clk); req_vld = '0;
      #1;
      check("t1_rd_en", 512'(rd_en), 512'(1));
      check("t1_rd_addr", 512'(rd_addr), 512'(15'h0123));
      check("t1_busy", 512'(busy), 512'(1));
      @(negedge clk); #1 check("t1_rd_en_pulse", 512'(rd_en), 512'(0));
      @(negedge clk);
      @(negedge clk); rd_valid = 1'b1; rd_data = {exp1[3], exp1[2], exp1[1], exp1[0]};
      #1 check("t1_no_early_vld", 512'(o_vld), 512'(0));
      @(negedge clk); rd_valid = 1'b0; rd_data = '0; o_rdy = 1'b1;
      #1;
      for (int b = 0; b < 4; b++) begin
         check("t1_vld", 512'(o_vld), 512'(1));
         check("t1_data", 512'(o_data), 512'(exp1[b]));
         check("t1_ch", 512'(o_ch), 512'(2));
         check("t1_last", 512'(o_last), 512'(b == 3));
         @(negedge clk); #1;
      end
      check("t1_busy_drop", 512'(busy), 512'(0));
      check("t1_vld_drop", 512'(o_vld), 512'(0));
      o_rdy = 1'b0;

      // Backpressure: out_rdy pattern 1,0,0,1 during DRAIN on ch 1
      @(negedge clk);
      req_vld = 4'b0010; req_addr[AW +: AW] = 15'h0456;
      #1 check("bp_gnt", 512'(req_rdy), 512'(4'b0010));
      @(negedge clk); req_vld = '0;
      @(negedge clk); rd_valid = 1'b1; rd_data = {exp2[3], exp2[2], exp2[1], exp2[0]};
      @(negedge clk); rd_valid = 1'b0; rd_data = '0;
      k = 0; cyc = 0; prev_stall = 1'b0; prev_data = '0; prev_ch = '0;
      while (k < 4 && cyc < 20) begin
         o_rdy = (cyc % 4 == 0) || (cyc % 4 == 3);
         #1;
         if (prev_stall) begin
            check("bp_stall_data", 512'(o_data), 512'(prev_data));
            check("bp_stall_ch", 512'(o_ch), 512'(prev_ch));
         end
         if (o_vld && o_rdy) begin
            check("bp_data", 512'(o_data), 512'(exp2[k]));
            check("bp_ch", 512'(o_ch), 512'(1));
            check("bp_last", 512'(o_last), 512'(k == 3));
            k++;
            prev_stall = 1'b0;
         end else begin
            prev_stall = o_vld;
         end
         prev_data = o_data; prev_ch = o_ch;
         @(negedge clk); cyc++;
      end
      o_rdy = 1'b0;
      #1;
      check("bp_beats", 512'(k), 512'(4));
      check("bp_no_extra", 512'(o_vld), 512'(0));

      // Round-robin from reset: all request, then only ch 1 and ch 3
      @(negedge clk); rst = 1'b1;
      @(negedge clk); rst = 1'b0;
      @(negedge clk);
      req_vld = 4'b1111;
      for (int i = 0; i < 9; i++) begin
         if (i == 6) req_vld = 4'b1010;
         serve(any_line, 1, g);
         check("rr_gnt", 512'(g), 512'(rr_exp[i]));
      end
      req_vld = '0;

      // Timeout after 8 WAIT cycles with no read data
      @(negedge clk);
      req_vld = 4'b0001;
      #1 check("to_gnt", 512'(req_rdy), 512'(4'b0001));
      @(negedge clk); req_vld = '0;
      repeat (8) @(negedge clk);
      #1;
      check("to_err_pre", 512'(err), 512'(0));
      check("to_busy_pre", 512'(busy), 512'(1));
      check("to_no_vld", 512'(o_vld), 512'(0));
      @(negedge clk); #1;
      check("to_err_set", 512'(err), 512'(1));
      check("to_idle", 512'(busy), 512'(0));
      check("to_no_beat", 512'(o_vld), 512'(0));
      req_vld = 4'b0100;
      serve(any_line, 2, g);
      req_vld = '0;
      check("to_next_gnt", 512'(g), 512'(2));
      check("to_err_sticky", 512'(err), 512'(1));
      err_clr = 1'b1;
      @(negedge clk); err_clr = 1'b0;
      #1 check("to_err_clr", 512'(err), 512'(0));
      err_clr = 1'b1; req_vld = 4'b0001;
      @(negedge clk); req_vld = '0;
      repeat (8) @(negedge clk);
      #1 check("to_clr_held", 512'(err), 512'(0));
      @(negedge clk); #1;
      check("to_set_beats_clr", 512'(err), 512'(1));
      err_clr = 1'b0;

      // Spurious read valid while idle
      @(negedge clk);
      rd_valid = 1'b1; rd_data = any_line;
      @(negedge clk); rd_valid = 1'b0; rd_data = '0;
      #1;
      check("spur_vld", 512'(o_vld), 512'(0));
      check("spur_busy", 512'(busy), 512'(0));

      // Reset in the middle of DRAIN (ptr is 1, so ch 3 wins)
      @(negedge clk);
      req_vld = 4'b1000; req_addr[3*AW +: AW] = 15'h0777;
      #1 check("mr_gnt", 512'(req_rdy), 512'(4'b1000));
      @(negedge clk); req_vld = '0;
      @(negedge clk); rd_valid = 1'b1; rd_data = {exp3[3], exp3[2], exp3[1], exp3[0]};
      @(negedge clk); rd_valid = 1'b0; rd_data = '0; o_rdy = 1'b1;
      #1 check("mr_beat0", 512'(o_data), 512'(exp3[0]));
      @(negedge clk); #1 check("mr_beat1", 512'(o_data), 512'(exp3[1]));
      @(negedge clk); req_vld = 4'b1111;
      #1 check("mr_beat2", 512'(o_data), 512'(exp3[2]));
      #1 rst = 1'b1;
      #1;
      check("mr_vld_async", 512'(o_vld), 512'(0));
      check("mr_rdy_async", 512'(req_rdy), 512'(0));
      check("mr_busy_async", 512'(busy), 512'(0));
      @(negedge clk); rst = 1'b0;
      #1 check("mr_first_gnt", 512'(req_rdy), 512'(4'b0001));
      req_vld = '0; o_rdy = 1'b0;
      @(negedge clk); #1 check("mr_no_beats", 512'(o_vld), 512'(0));

      // Single-channel, single-beat build
      @(negedge clk);
      s_req_vld = 1'b1; s_req_addr = 15'h0055;
      #1 check("sw_gnt", 512'(s_req_rdy), 512'(1));
      @(negedge clk); s_req_vld = 1'b0;
      #1;
      check("sw_rd_en", 512'(s_rd_en), 512'(1));
      check("sw_rd_addr", 512'(s_rd_addr), 512'(15'h0055));
      @(negedge clk); s_rd_valid = 1'b1; s_rd_data = {128'h5A5A, 128'hC3C3};
      @(negedge clk); s_rd_valid = 1'b0; s_rd_data = '0;
      #1;
      check("sw_vld", 512'(s_o_vld), 512'(1));
      check("sw_last", 512'(s_o_last), 512'(1));
      check("sw_ch", 512'(s_o_ch), 512'(0));
      check("sw_data", 512'(s_o_data), 512'({128'h5A5A, 128'hC3C3}));
      s_o_rdy = 1'b1;
      @(negedge clk); #1;
      check("sw_busy_drop", 512'(s_busy), 512'(0));
      check("sw_vld_drop", 512'(s_o_vld), 512'(0));
      check("sw_err", 512'(s_err), 512'(0));
      s_o_rdy = 1'b0;

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
